rdoq_last_trim: RTL and testbench
=================================

# rdoq_last_trim

Post-RDOQ coefficient trimming stage, directly downstream of the last-position optimizer. Once the optimizer has chosen the best last index (`best_last_idx_p1`), this block walks the transform block in scan order. It zeroes every coefficient at or beyond that scan position in the shared coefficient RAM. In the same pass it rebuilds the side information the entropy coder and sign-data-hiding stage need: per-CG significance flags, nonzero count, absolute sum and the block position of the final last coefficient. It streams one scan position per cycle through a 3-stage read pipeline.

## Interface
- MAX_COEFF_COUNT, 1024: maximum coefficients per block.
- ADDR_WIDTH, 10: coefficient/scan address width, equal to log2(MAX_COEFF_COUNT).
- CG_SIZE, 16: coefficients per coefficient group.
- COEFF_WIDTH, 16: signed coefficient width.
- NUM_CG, MAX_COEFF_COUNT/CG_SIZE: derived localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- best_last_idx_p1  in  ADDR_WIDTH+1  first scan position to zero; captured on start.
- num_coeff  in  ADDR_WIDTH+1  scan positions in this block (0..MAX_COEFF_COUNT); captured on start.
- busy  out  1  high from the cycle after start until the cycle before done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- so_rd_en / so_rd_addr  out  1 / ADDR_WIDTH  scan-order ROM read.
- so_rd_data  in  ADDR_WIDTH  blk_pos; 1-cycle read latency.
- coef_rd_en / coef_rd_addr  out  1 / ADDR_WIDTH  coefficient RAM read.
- coef_rd_data  in  COEFF_WIDTH signed  1-cycle read latency.
- coef_wr_en / coef_wr_addr / coef_wr_data  out  1 / ADDR_WIDTH / COEFF_WIDTH  coefficient RAM write.
- sig_cg_flag  out  NUM_CG  bit g set when any surviving nonzero lies in scan positions g*CG_SIZE..g*CG_SIZE+CG_SIZE-1.
- nz_count  out  ADDR_WIDTH+1  surviving nonzero count.
- abs_sum  out  ADDR_WIDTH+COEFF_WIDTH  sum of |coef| over survivors.
- last_blk_pos  out  ADDR_WIDTH  blk_pos of the highest surviving nonzero scan position.
- last_valid  out  1  at least one survivor.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start: capture both inputs, clear all accumulators.
  - RUN issues scan positions 0..N-1, one per cycle.
  - RUN→DRAIN after position N-1 has been issued.
  - DRAIN→DONE when the pipeline is empty.
  - DONE→IDLE unconditionally after 1 cycle.
- Pipeline per scan position k:
  - S0: so_rd_en=1, so_rd_addr=k.
  - S1: coef_rd_en=1, coef_rd_addr=so_rd_data.
  - S2: evaluate coef_rd_data.
- S2 rule, for k ≥ best_last_idx_p1:
  - A nonzero coefficient is written to 0 at blk_pos in the following cycle.
  - A zero coefficient causes no write.
  - No accumulation.
- S2 rule, for k < best_last_idx_p1 with a nonzero coefficient:
  - nz_count += 1.
  - abs_sum += |coef|. |−2^(COEFF_WIDTH−1)| = 2^(COEFF_WIDTH−1), computed unsigned with no saturation.
  - Set sig_cg_flag[k/CG_SIZE].
  - last_blk_pos ← blk_pos, last_valid ← 1.
- Only nonzero→zero changes produce writes. Untouched coefficients are never rewritten.
- The scan order is a permutation, so each address is read once and written at most once. No read/write hazard logic is needed.
- best_last_idx_p1 > num_coeff: nothing is zeroed.
- best_last_idx_p1 = 0: all nonzeros are zeroed and last_valid=0.
- num_coeff = 0: no memory accesses, and done follows without any RUN cycles.
- start outside IDLE is ignored. Inputs are sampled only on the accepted start.

## Timing
- start accepted at edge T.
  - Position k is issued to S0 in cycle T+1+k.
  - Its coefficient read is in T+2+k.
  - Its write, if any, is in T+4+k.
- done pulses in cycle T+N+4 for N ≥ 1, and in T+2 for N = 0.
- busy is high in cycles T+1 .. T+N+3, and for N = 0 only in T+1.
- Result outputs are registered and hold their value until the next accepted start clears them.
- Reset values:
  - busy, done, so_rd_en, coef_rd_en, coef_wr_en are 0.
  - All address, data and result outputs are 0.
  - State is IDLE.
- Reset asserted mid-run aborts immediately. No further reads or writes are issued, and already-issued writes are not replayed.

## Test plan
- num_coeff=16, identity scan, coefs 5,0,−3,1 then zeros, best_last_idx_p1=3 → one write: addr 3 data 0. nz_count=2, abs_sum=8, sig_cg_flag[0]=1, last_blk_pos=2. done at T+20.
- num_coeff=64, nonzero 2 at scan positions 0, 20, 40, best_last_idx_p1=21 → write at blk of pos 40 only. sig_cg_flag=4'b0011, nz_count=2, abs_sum=4.
- best_last_idx_p1=0, four nonzeros → four writes, last_valid=0, nz_count=0, sig_cg_flag=0.
- num_coeff=1024, reversed scan, best_last_idx_p1=1024, coef −32768 at pos 1023 → no writes. abs_sum=32768, last_blk_pos=0. done at T+1028, busy held for exactly 1027 cycles.
- num_coeff=0 → done at T+2, no enables asserted. A start during busy is ignored and outputs are unchanged.
- rst_n pulsed low at T+10 of a 64-coefficient run → all outputs read 0 during reset, no writes after reset. A fresh start then completes normally.

Source files
------------

// File: rtl/rdoq_last_trim.sv
// rdoq_last_trim: walks a transform block in scan order after the last-position
// optimizer has chosen best_last_idx_p1. It zeroes every nonzero coefficient at or
// beyond that scan position in the shared coefficient RAM. In the same pass it
// rebuilds the significance/count/sum/last-position side information for the survivors.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle request, honoured only while idle
//   best_last_idx_p1, num_coeff first scan position to zero / scan length, captured on start
//   busy, done                  run in progress / one-cycle completion pulse
//   so_rd_*                     scan-order ROM read port (1-cycle latency)
//   coef_rd_*                   coefficient RAM read port (1-cycle latency)
//   coef_wr_*                   coefficient RAM write port (writes zeros only)
//   sig_cg_flag, nz_count, abs_sum, last_blk_pos, last_valid
//                               registered results, valid from done until the next start
//
// Pipeline per scan position k: S0 reads the scan ROM, S1 reads the coefficient
// RAM at the returned blk_pos, S2 evaluates the coefficient. A resulting write
// is registered and appears on the write port one cycle after S2.
module rdoq_last_trim #(
  parameter int MAX_COEFF_COUNT = 1024,
  parameter int ADDR_WIDTH      = 10,
  parameter int CG_SIZE         = 16,
  parameter int COEFF_WIDTH     = 16,
  localparam int NUM_CG         = MAX_COEFF_COUNT / CG_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH:0]                best_last_idx_p1,
  input  logic [ADDR_WIDTH:0]                num_coeff,
  output logic                               busy,
  output logic                               done,
  output logic                               so_rd_en,
  output logic [ADDR_WIDTH-1:0]              so_rd_addr,
  input  logic [ADDR_WIDTH-1:0]              so_rd_data,
  output logic                               coef_rd_en,
  output logic [ADDR_WIDTH-1:0]              coef_rd_addr,
  input  logic signed [COEFF_WIDTH-1:0]      coef_rd_data,
  output logic                               coef_wr_en,
  output logic [ADDR_WIDTH-1:0]              coef_wr_addr,
  output logic [COEFF_WIDTH-1:0]             coef_wr_data,
  output logic [NUM_CG-1:0]                  sig_cg_flag,
  output logic [ADDR_WIDTH:0]                nz_count,
  output logic [ADDR_WIDTH+COEFF_WIDTH-1:0]  abs_sum,
  output logic [ADDR_WIDTH-1:0]              last_blk_pos,
  output logic                               last_valid
);

  localparam int CG_SHIFT = $clog2(CG_SIZE);
  localparam int CG_IDX_W = ADDR_WIDTH - CG_SHIFT;
  localparam int SUM_W    = ADDR_WIDTH + COEFF_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   cnt;       // next scan position to issue
  logic [ADDR_WIDTH:0]   num_q;     // captured scan length
  logic [ADDR_WIDTH:0]   blp1_q;    // captured first scan position to zero

  // S1: scan ROM data is arriving this cycle for position s1_k.
  logic                  s1_vld;
  logic [ADDR_WIDTH-1:0] s1_k;
  // S2: coefficient data is arriving this cycle for position s2_k at blk_pos s2_pos.
  logic                  s2_vld;
  logic [ADDR_WIDTH-1:0] s2_k;
  logic [ADDR_WIDTH-1:0] s2_pos;

  logic                  accept;
  logic                  issue;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  s2_nz;
  logic                  s2_keep;
  logic [COEFF_WIDTH-1:0] s2_raw;
  logic [COEFF_WIDTH-1:0] s2_abs;
  logic [CG_IDX_W-1:0]   s2_cg;

  always_comb begin
    accept  = (state == ST_IDLE) && start;
    issue   = (state == ST_RUN) && (cnt < num_q);
    cnt_nxt = cnt + (ADDR_WIDTH+1)'(1);
    s2_nz   = s2_vld && (coef_rd_data != '0);
    s2_keep = ({1'b0, s2_k} < blp1_q);
    s2_raw  = coef_rd_data;
    // Two's-complement magnitude taken as unsigned, so the most negative code
    // maps to 2^(COEFF_WIDTH-1) instead of overflowing.
    s2_abs  = s2_raw[COEFF_WIDTH-1] ? (~s2_raw + COEFF_WIDTH'(1)) : s2_raw;
    s2_cg   = s2_k[ADDR_WIDTH-1:CG_SHIFT];
  end

  // Read ports. The coefficient address comes straight from the scan ROM data,
  // gated so idle and reset cycles present zero addresses.
  assign so_rd_en     = issue;
  assign so_rd_addr   = issue ? cnt[ADDR_WIDTH-1:0] : '0;
  assign coef_rd_en   = s1_vld;
  assign coef_rd_addr = s1_vld ? so_rd_data : '0;
  assign coef_wr_data = '0;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      num_q  <= '0;
      blp1_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_RUN;
            cnt    <= '0;
            num_q  <= num_coeff;
            blp1_q <= best_last_idx_p1;
          end
        end
        ST_RUN: begin
          // An empty block never issues anything and finishes straight away.
          if (num_q == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == num_q) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The write stage needs no wait of its own: once S1 and S2 are empty
          // the last write is on the port this cycle.
          if (!s1_vld && !s2_vld) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read pipeline and write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld       <= 1'b0;
      s1_k         <= '0;
      s2_vld       <= 1'b0;
      s2_k         <= '0;
      s2_pos       <= '0;
      coef_wr_en   <= 1'b0;
      coef_wr_addr <= '0;
    end else begin
      s1_vld <= issue;
      if (issue) begin
        s1_k <= cnt[ADDR_WIDTH-1:0];
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_k   <= s1_k;
        s2_pos <= so_rd_data;
      end
      // Only a nonzero beyond the cut is rewritten; zeros are left untouched.
      coef_wr_en <= s2_nz && !s2_keep;
      if (s2_nz && !s2_keep) begin
        coef_wr_addr <= s2_pos;
      end
    end
  end

  // Survivor statistics, cleared on every accepted start and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_cg_flag  <= '0;
      nz_count     <= '0;
      abs_sum      <= '0;
      last_blk_pos <= '0;
      last_valid   <= 1'b0;
    end else if (accept) begin
      sig_cg_flag  <= '0;
      nz_count     <= '0;
      abs_sum      <= '0;
      last_blk_pos <= '0;
      last_valid   <= 1'b0;
    end else if (s2_nz && s2_keep) begin
      nz_count            <= nz_count + (ADDR_WIDTH+1)'(1);
      abs_sum             <= abs_sum + SUM_W'(s2_abs);
      sig_cg_flag[s2_cg]  <= 1'b1;
      // Scan positions arrive in increasing order, so the latest survivor is the last one.
      last_blk_pos        <= s2_pos;
      last_valid          <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rdoq_last_trim.sv
module tb_rdoq_last_trim;

  localparam int AW   = 10;
  localparam int CW   = 16;
  localparam int MAXC = 1024;
  localparam int NCG  = MAXC / 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW:0]          best_last_idx_p1 = '0;
  logic [AW:0]          num_coeff = '0;
  logic                 busy, done;
  logic                 so_rd_en;
  logic [AW-1:0]        so_rd_addr;
  logic [AW-1:0]        so_rd_data = '0;
  logic                 coef_rd_en;
  logic [AW-1:0]        coef_rd_addr;
  logic signed [CW-1:0] coef_rd_data = '0;
  logic                 coef_wr_en;
  logic [AW-1:0]        coef_wr_addr;
  logic [CW-1:0]        coef_wr_data;
  logic [NCG-1:0]       sig_cg_flag;
  logic [AW:0]          nz_count;
  logic [AW+CW-1:0]     abs_sum;
  logic [AW-1:0]        last_blk_pos;
  logic                 last_valid;

  rdoq_last_trim dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .best_last_idx_p1(best_last_idx_p1), .num_coeff(num_coeff),
    .busy(busy), .done(done),
    .so_rd_en(so_rd_en), .so_rd_addr(so_rd_addr), .so_rd_data(so_rd_data),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .sig_cg_flag(sig_cg_flag), .nz_count(nz_count), .abs_sum(abs_sum),
    .last_blk_pos(last_blk_pos), .last_valid(last_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories: scan ROM and coefficient RAM contents are set by the stimulus
  // before each run; DUT writes are checked by the scoreboard only.
  logic [AW-1:0]        scan_rom [MAXC];
  logic signed [CW-1:0] coef_mem [MAXC];

  always @(posedge clk) begin
    if (so_rd_en)   so_rd_data   <= scan_rom[so_rd_addr];
    if (coef_rd_en) coef_rd_data <= coef_mem[coef_rd_addr];
  end

  typedef struct {
    int addr;
    int cyc;
  } wr_t;

  typedef struct {
    int             nz;
    longint         sum;
    logic [NCG-1:0] sig;
    int             lbp;
    int             lv;
    int             done_cyc;
    int             busy;
    int             nrd;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  res_t last_res;
  wr_t  mw;
  res_t mr;

  int n_vec = 0;
  int n_err = 0;
  int last_t0 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  int busy_cnt = 0, srd_cnt = 0, crd_cnt = 0, runs_done = 0, wr_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      srd_cnt  = 0;
      crd_cnt  = 0;
    end else begin
      if (busy)       busy_cnt++;
      if (so_rd_en)   srd_cnt++;
      if (coef_rd_en) crd_cnt++;
      if (coef_wr_en) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got write to addr %0d at cycle %0d, expected no write", coef_wr_addr, cyc);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", 64'(coef_wr_addr), 64'(mw.addr));
          chk("wr_cycle", 64'(cyc), 64'(mw.cyc));
          chk("wr_data", 64'(coef_wr_data), 64'd0);
        end
      end
      if (done) begin
        runs_done++;
        if (res_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          mr = res_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mr.done_cyc));
          chk("nz_count", 64'(nz_count), 64'(mr.nz));
          chk("abs_sum", 64'(abs_sum), 64'(mr.sum));
          chk("sig_cg_flag", 64'(sig_cg_flag), 64'(mr.sig));
          chk("last_blk_pos", 64'(last_blk_pos), 64'(mr.lbp));
          chk("last_valid", 64'(last_valid), 64'(mr.lv));
          chk("busy_cycles", 64'(busy_cnt), 64'(mr.busy));
          chk("so_rd_count", 64'(srd_cnt), 64'(mr.nrd));
          chk("coef_rd_count", 64'(crd_cnt), 64'(mr.nrd));
          chk("writes_pending_at_done", 64'(wr_q.size()), 64'd0);
        end
        busy_cnt = 0;
        srd_cnt  = 0;
        crd_cnt  = 0;
      end
    end
  end

  // Reference model: applies the trimming rules directly to the memory contents.
  task automatic push_model(input int n, input int blp1, input int t0);
    res_t r;
    wr_t  w;
    r.nz = 0; r.sum = 0; r.sig = '0; r.lbp = 0; r.lv = 0;
    for (int k = 0; k < n; k++) begin
      int p;
      int c;
      p = int'(scan_rom[k]);
      c = coef_mem[p];
      if (c != 0) begin
        if (k >= blp1) begin
          w.addr = p;
          w.cyc  = t0 + 3 + k;
          wr_q.push_back(w);
        end else begin
          r.nz++;
          r.sum += (c < 0) ? -c : c;
          r.sig[k / 16] = 1'b1;
          r.lbp = p;
          r.lv  = 1;
        end
      end
    end
    r.done_cyc = (n == 0) ? t0 + 1 : t0 + n + 3;
    r.busy     = (n == 0) ? 1 : n + 3;
    r.nrd      = n;
    res_q.push_back(r);
    last_res = r;
  endtask

  task automatic issue(input int n, input int blp1);
    @(negedge clk);
    start            = 1'b1;
    num_coeff        = (AW+1)'(n);
    best_last_idx_p1 = (AW+1)'(blp1);
    @(negedge clk);
    start   = 1'b0;
    last_t0 = cyc;
    // Inputs are only sampled on the accepted start; scramble them afterwards.
    num_coeff        = (AW+1)'($urandom);
    best_last_idx_p1 = (AW+1)'($urandom);
    push_model(n, blp1, last_t0);
  endtask

  task automatic wait_run(input int tgt, input int budget);
    int i;
    i = 0;
    while (runs_done < tgt && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (runs_done < tgt) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic check_hold();
    repeat (3) @(negedge clk);
    chk("hold_nz_count", 64'(nz_count), 64'(last_res.nz));
    chk("hold_abs_sum", 64'(abs_sum), 64'(last_res.sum));
    chk("hold_sig_cg_flag", 64'(sig_cg_flag), 64'(last_res.sig));
    chk("hold_last_blk_pos", 64'(last_blk_pos), 64'(last_res.lbp));
  endtask

  task automatic run(input int n, input int blp1);
    int tgt;
    tgt = runs_done + 1;
    issue(n, blp1);
    wait_run(tgt, n + 50);
    check_hold();
  endtask

  task automatic set_identity();
    for (int i = 0; i < MAXC; i++) scan_rom[i] = AW'(i);
  endtask

  task automatic set_reverse();
    for (int i = 0; i < MAXC; i++) scan_rom[i] = AW'(MAXC - 1 - i);
  endtask

  task automatic set_perm();
    logic [AW-1:0] tmp;
    int j;
    set_identity();
    for (int i = MAXC - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp         = scan_rom[i];
      scan_rom[i] = scan_rom[j];
      scan_rom[j] = tmp;
    end
  endtask

  task automatic clear_coefs();
    for (int i = 0; i < MAXC; i++) coef_mem[i] = '0;
  endtask

  task automatic rand_coefs();
    int r;
    for (int i = 0; i < MAXC; i++) begin
      r = int'($urandom_range(3, 0));
      if ($urandom_range(40, 0) == 0)  coef_mem[i] = 16'sh8000;
      else if (r == 0)                 coef_mem[i] = CW'($urandom);
      else if (r == 1)                 coef_mem[i] = CW'(int'($urandom_range(8, 0)) - 4);
      else                             coef_mem[i] = '0;
    end
  endtask

  initial begin
    int n;
    int tgt;
    int ws;

    clear_coefs();
    set_identity();

    // Reset state
    #12;
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_enables", 64'({so_rd_en, coef_rd_en, coef_wr_en}), 64'd0);
    chk("rst_addrs", 64'({so_rd_addr, coef_rd_addr, coef_wr_addr, coef_wr_data}), 64'd0);
    chk("rst_results", 64'({nz_count, last_blk_pos, last_valid}), 64'd0);
    chk("rst_abs_sum", 64'(abs_sum), 64'd0);
    chk("rst_sig_cg_flag", 64'(sig_cg_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity scan, 5,0,-3,1: one trailing write at blk 3
    clear_coefs();
    set_identity();
    coef_mem[0] = 16'sd5;
    coef_mem[2] = -16'sd3;
    coef_mem[3] = 16'sd1;
    run(16, 3);
    chk("tp1_nz", 64'(nz_count), 64'd2);
    chk("tp1_abs", 64'(abs_sum), 64'd8);
    chk("tp1_last", 64'(last_blk_pos), 64'd2);

    // Nonzeros at scan 0, 20, 40 with the cut at 21
    clear_coefs();
    coef_mem[0]  = 16'sd2;
    coef_mem[20] = 16'sd2;
    coef_mem[40] = 16'sd2;
    run(64, 21);
    chk("tp2_sig", 64'(sig_cg_flag), 64'h3);

    // Cut at 0: everything nonzero is zeroed
    clear_coefs();
    set_perm();
    coef_mem[scan_rom[1]]  = 16'sd7;
    coef_mem[scan_rom[5]]  = -16'sd1;
    coef_mem[scan_rom[9]]  = 16'sd100;
    coef_mem[scan_rom[15]] = -16'sd20;
    run(16, 0);
    chk("tp3_last_valid", 64'(last_valid), 64'd0);

    // Full block, reversed scan, most negative coefficient at the last position
    clear_coefs();
    set_reverse();
    coef_mem[0] = 16'sh8000;
    run(MAXC, MAXC);
    chk("tp4_abs", 64'(abs_sum), 64'd32768);
    chk("tp4_last", 64'(last_blk_pos), 64'd0);

    // Empty block
    run(0, 5);

    // Cut beyond the block length: nothing zeroed
    rand_coefs();
    set_perm();
    run(40, 45);

    // Start while busy is ignored
    rand_coefs();
    set_perm();
    tgt = runs_done + 1;
    issue(40, 25);
    repeat (5) @(negedge clk);
    start = 1'b1;
    num_coeff = 11'd7;
    best_last_idx_p1 = 11'd2;
    @(negedge clk);
    start = 1'b0;
    wait_run(tgt, 100);
    repeat (10) @(negedge clk);
    chk("ignored_start_runs", 64'(runs_done), 64'(tgt));
    check_hold();

    // Randomized runs
    for (int t = 0; t < 10; t++) begin
      rand_coefs();
      set_perm();
      n = (t == 4) ? MAXC : int'($urandom_range(200, 1));
      run(n, int'($urandom_range(n + 4, 0)));
    end

    // Reset in the middle of a 64-coefficient run
    rand_coefs();
    set_perm();
    tgt = runs_done;
    issue(64, 30);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    wr_q.delete();
    res_q.delete();
    chk("midrst_busy_done", 64'({busy, done}), 64'd0);
    chk("midrst_enables", 64'({so_rd_en, coef_rd_en, coef_wr_en}), 64'd0);
    chk("midrst_addrs", 64'({so_rd_addr, coef_rd_addr, coef_wr_addr}), 64'd0);
    chk("midrst_results", 64'({nz_count, last_blk_pos, last_valid}), 64'd0);
    chk("midrst_abs_sum", 64'(abs_sum), 64'd0);
    chk("midrst_sig", 64'(sig_cg_flag), 64'd0);
    ws = wr_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("midrst_no_writes", 64'(wr_seen - ws), 64'd0);
    chk("midrst_no_done", 64'(runs_done), 64'(tgt));

    // Fresh run after the abort
    rand_coefs();
    set_perm();
    run(64, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
